// File: rtl/avalon_key_led_pio_if.sv
// Avalon-MM slave bus bundle for the key/LED PIO, including its level interrupt.
// Latency: none (wiring only).
// Backpressure: none; the slave never stalls, so there is no waitrequest.
interface avalon_key_led_pio_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, read, write, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/avalon_key_led_pio.sv
// Key/LED PIO: synchronised, debounced keys with edge-capture IRQ, and LEDs with set/clear plus a blink mode.
// Latency: readdata 1 cycle after read; leds_out 1 cycle after any LED register write; keys 2 sync + DEB_CYCLES.
// Backpressure: none; every read and write is accepted in the cycle it is presented.
module avalon_key_led_pio #(
  parameter int KEY_W          = 3,
  parameter int LED_W          = 26,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int DEB_CYCLES     = 50000,
  parameter int DEB_CNT_W      = 16,
  parameter int BLINK_RST      = 25000000
) (
  input  logic                 clk,
  input  logic                 reset,
  avalon_key_led_pio_if.slave  bus,
  input  logic [KEY_W-1:0]     keys_in,
  output logic [LED_W-1:0]     leds_out
);

  // Raw pin level that means "not pressed"; the sync flops come out of reset there so no phantom press occurs.
  localparam logic [KEY_W-1:0]     LP_KEY_REL = (KEY_ACTIVE_LOW != 0) ? {KEY_W{1'b1}} : {KEY_W{1'b0}};
  localparam logic [DEB_CNT_W-1:0] LP_DEB_MAX = DEB_CNT_W'(DEB_CYCLES - 1);

  logic [KEY_W-1:0]     r_sync1;
  logic [KEY_W-1:0]     r_sync2;
  logic [KEY_W-1:0]     w_synced;
  logic [KEY_W-1:0]     r_key_data;
  logic [DEB_CNT_W-1:0] r_deb_cnt [KEY_W];
  logic [KEY_W-1:0]     w_deb_rise;
  logic [KEY_W-1:0]     r_key_edge;
  logic [KEY_W-1:0]     w_edge_clr;
  logic [KEY_W-1:0]     r_irq_mask;
  logic [LED_W-1:0]     r_led_data;
  logic [LED_W-1:0]     r_blink_mask;
  logic [31:0]          r_blink_div;
  logic [31:0]          r_blink_cnt;
  logic                 r_phase;
  logic [31:0]          w_rd_mux;
  logic [31:0]          r_readdata;
  logic                 w_wr_div;

  // Two-flop synchroniser on the raw pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= LP_KEY_REL;
      r_sync2 <= LP_KEY_REL;
    end else begin
      r_sync1 <= keys_in;
      r_sync2 <= r_sync1;
    end
  end

  // Everything downstream of the synchroniser sees pressed = 1.
  assign w_synced = (KEY_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  // A key is accepted as newly pressed on the cycle its debounce counter expires with the synced level high.
  always_comb begin
    w_deb_rise = '0;
    for (int i = 0; i < KEY_W; i++) begin
      w_deb_rise[i] = w_synced[i] & ~r_key_data[i] & (r_deb_cnt[i] == LP_DEB_MAX);
    end
  end

  // Per-key debounce: count consecutive disagreeing cycles, adopt the synced level after DEB_CYCLES of them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_data <= '0;
      for (int i = 0; i < KEY_W; i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < KEY_W; i++) begin
        if (w_synced[i] == r_key_data[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == LP_DEB_MAX) begin
          r_key_data[i] <= w_synced[i];
          r_deb_cnt[i]  <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DEB_CNT_W'(1);
        end
      end
    end
  end

  assign w_edge_clr = (bus.write && bus.address == 3'd1) ? bus.writedata[KEY_W-1:0] : '0;
  assign w_wr_div   = bus.write && bus.address == 3'd7;

  // Edge capture; a new press beats a simultaneous write-1-to-clear so no press is ever lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_edge <= '0;
    end else begin
      r_key_edge <= (r_key_edge & ~w_edge_clr) | w_deb_rise;
    end
  end

  // Plain RW/WO control registers; write data is truncated to each register's width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_mask   <= '0;
      r_led_data   <= '0;
      r_blink_mask <= '0;
      r_blink_div  <= 32'(BLINK_RST);
    end else if (bus.write) begin
      case (bus.address)
        3'd2:    r_irq_mask   <= bus.writedata[KEY_W-1:0];
        3'd3:    r_led_data   <= bus.writedata[LED_W-1:0];
        3'd4:    r_led_data   <= r_led_data | bus.writedata[LED_W-1:0];
        3'd5:    r_led_data   <= r_led_data & ~bus.writedata[LED_W-1:0];
        3'd6:    r_blink_mask <= bus.writedata[LED_W-1:0];
        3'd7:    r_blink_div  <= bus.writedata;
        default: ;
      endcase
    end
  end

  // Blink timebase: down-counter reloads from BLINK_DIV and toggles the phase at zero; a divider of 0 parks it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_wr_div) begin
      r_blink_cnt <= bus.writedata;
      r_phase     <= 1'b0;
    end else if (r_blink_div == 32'd0) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == 32'd0) begin
      r_blink_cnt <= r_blink_div;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt - 32'd1;
    end
  end

  // Registered LED drive with the blink phase XORed into the masked bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_out <= '0;
    end else begin
      leds_out <= r_led_data ^ (r_blink_mask & {LED_W{r_phase}});
    end
  end

  // Read mux over current register contents, so a same-cycle write returns the pre-write value.
  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      3'd0:    w_rd_mux[KEY_W-1:0] = r_key_data;
      3'd1:    w_rd_mux[KEY_W-1:0] = r_key_edge;
      3'd2:    w_rd_mux[KEY_W-1:0] = r_irq_mask;
      3'd3:    w_rd_mux[LED_W-1:0] = r_led_data;
      3'd6:    w_rd_mux[LED_W-1:0] = r_blink_mask;
      3'd7:    w_rd_mux            = r_blink_div;
      default: w_rd_mux            = '0;
    endcase
  end

  // Read data register; returns 0 on idle cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= bus.read ? w_rd_mux : 32'd0;
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = |(r_key_edge & r_irq_mask);

endmodule

// File: tb/tb_avalon_key_led_pio.sv
// Bench for avalon_key_led_pio: directed bus/pin stimulus, reads checked by a queue-driven monitor.
// Latency: read results are compared one cycle after the read strobe.
// Backpressure: none; the DUT accepts every access.
module tb_avalon_key_led_pio;

  logic        clk;
  logic        reset;
  logic [2:0]  keys_in;
  logic [25:0] leds_out;

  avalon_key_led_pio_if bus ();

  avalon_key_led_pio #(
    .KEY_W(3), .LED_W(26), .KEY_ACTIVE_LOW(1),
    .DEB_CYCLES(4), .DEB_CNT_W(16), .BLINK_RST(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .keys_in(keys_in),
    .leds_out(leds_out)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  logic rd_q    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read monitor: one cycle after a read strobe, pop the expected value and compare.
  always @(posedge clk) rd_q <= bus.read;

  always @(negedge clk) begin
    if (rd_q) begin
      n_total++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_read got=0x%08h expected no read", bus.readdata);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (bus.readdata !== e.exp) begin
          n_bad++;
          $display("FAIL %s got=0x%08h expected=0x%08h", e.name, bus.readdata, e.exp);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus cycle starting just after a rising edge; a read pushes its expected value.
  task automatic bus_op(input bit rd, input bit wr, input logic [2:0] addr,
                        input logic [31:0] wdat, input logic [31:0] exp, input string name);
    if (rd) begin
      sb_t e;
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
    end
    bus.address   = addr;
    bus.read      = rd;
    bus.write     = wr;
    bus.writedata = wdat;
    @(posedge clk);
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] wdat);
    bus_op(1'b0, 1'b1, addr, wdat, 32'd0, "");
  endtask

  task automatic bus_read(input logic [2:0] addr, input logic [31:0] exp, input string name);
    bus_op(1'b1, 1'b0, addr, 32'd0, exp, name);
  endtask

  // Pin check at the falling edge, then resynchronise to just after the next rising edge.
  task automatic chk_pin(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
    n_total++;
    if (act_sel !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h expected=0x%08h", name, act_sel, exp);
    end
  endtask

  task automatic chk_leds(input string name, input logic [25:0] exp);
    @(negedge clk);
    chk_pin(name, 32'(leds_out), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_irq(input string name, input logic exp);
    @(negedge clk);
    chk_pin(name, 32'(bus.irq), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    keys_in       = 3'b111;
    bus.address   = 3'd0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.writedata = 32'd0;

    // Reset: wiggle keys while held in reset; outputs must stay quiet.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      keys_in = 3'(i);
    end
    chk_leds("reset_leds", 26'd0);
    chk_irq("reset_irq", 1'b0);
    @(negedge clk);
    chk_pin("reset_readdata", bus.readdata, 32'd0);
    @(posedge clk);
    #1;
    keys_in = 3'b111;
    reset   = 1'b0;
    cycles(3);
    bus_read(3'd0, 32'd0, "rst_key_data");
    bus_read(3'd1, 32'd0, "rst_key_edge");
    bus_read(3'd7, 32'd3, "rst_blink_div");

    // Debounce: a 3-cycle glitch must be ignored.
    keys_in[0] = 1'b0;
    cycles(3);
    keys_in[0] = 1'b1;
    cycles(10);
    bus_read(3'd0, 32'd0, "glitch_key_data");
    bus_read(3'd1, 32'd0, "glitch_key_edge");

    // Debounce: held press lands exactly 2 sync + 4 stable cycles after the pin change.
    keys_in[0] = 1'b0;
    cycles(5);
    bus_read(3'd0, 32'd0, "press_not_early");
    bus_read(3'd0, 32'd1, "press_key_data");
    cycles(8);
    bus_read(3'd1, 32'd1, "press_key_edge");

    // Release updates the level but sets no edge.
    keys_in[0] = 1'b1;
    cycles(10);
    bus_read(3'd0, 32'd0, "release_key_data");
    bus_read(3'd1, 32'd1, "release_keeps_edge");

    // IRQ masking and W1C.
    bus_write(3'd1, 32'd1);
    bus_write(3'd2, 32'd1);
    chk_irq("irq_idle", 1'b0);
    keys_in[0] = 1'b0;
    cycles(10);
    chk_irq("irq_key0", 1'b1);
    bus_write(3'd1, 32'd1);
    chk_irq("irq_after_w1c", 1'b0);
    keys_in[0] = 1'b1;
    cycles(10);
    keys_in[1] = 1'b0;
    cycles(10);
    chk_irq("irq_key1_masked", 1'b0);
    bus_read(3'd1, 32'd2, "key1_edge");
    keys_in[1] = 1'b1;
    cycles(10);
    bus_write(3'd1, 32'd7);
    bus_read(3'd1, 32'd0, "edges_cleared");

    // Set/clear race: W1C lands on the same edge as the press is accepted.
    keys_in[0] = 1'b0;
    cycles(5);
    bus_write(3'd1, 32'd1);
    bus_read(3'd1, 32'd1, "race_set_wins");
    chk_irq("race_irq", 1'b1);
    keys_in[0] = 1'b1;
    cycles(10);
    bus_write(3'd1, 32'd1);
    bus_read(3'd1, 32'd0, "race_cleared");

    // LED set/clear, one-cycle output delay, WO reads, truncation, read-during-write.
    bus_write(3'd3, 32'h0F);
    bus_write(3'd4, 32'h30);
    bus_write(3'd5, 32'h03);
    chk_leds("leds_before_clr", 26'h3F);
    chk_leds("leds_after_clr", 26'h3C);
    bus_read(3'd3, 32'h3C, "led_data");
    bus_read(3'd4, 32'd0, "led_set_wo");
    bus_read(3'd5, 32'd0, "led_clr_wo");
    bus_write(3'd2, 32'hFFFF_FFFF);
    bus_read(3'd2, 32'h7, "irq_mask_trunc");
    bus_write(3'd2, 32'd0);
    bus_op(1'b1, 1'b1, 3'd3, 32'h55, 32'h3C, "rw_pre_write");
    bus_read(3'd3, 32'h55, "rw_post_write");

    // Blink: half-period of 4 cycles with BLINK_DIV=3, then parked by BLINK_DIV=0.
    bus_write(3'd3, 32'd0);
    bus_write(3'd6, 32'd1);
    bus_write(3'd7, 32'd3);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk_pin($sformatf("blink_k%0d", k), 32'(leds_out[0]), 32'(((k - 1) / 4) % 2));
    end
    @(posedge clk);
    #1;
    bus_write(3'd7, 32'd0);
    cycles(2);
    for (int k = 0; k < 4; k++) begin
      cycles(2);
      chk_leds("blink_off", 26'd0);
    end
    bus_read(3'd7, 32'd0, "blink_div_zero");
    bus_read(3'd6, 32'd1, "blink_mask");

    cycles(3);
    if (sb_q.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
